// File: rtl/rom_loader_bank.sv
// rtl/rom_loader_bank.sv - host-loadable multi-bank program ROM with byte-stream loader and registered CPU read port
module rom_loader_bank #(
  parameter int AW     = 13,
  parameter int DW     = 8,
  parameter int NBANKS = 2,
  parameter int BW     = (NBANKS > 1) ? $clog2(NBANKS) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [AW-1:0]     a,
  input  logic [BW-1:0]     bank,
  input  logic              ce,
  input  logic              oe,
  output logic [DW-1:0]     d,
  input  logic              ld_start,
  input  logic [BW-1:0]     ld_bank,
  input  logic              ld_valid,
  input  logic [7:0]        ld_data,
  output logic              ld_ready,
  input  logic              ld_finish,
  output logic              ld_busy,
  output logic              ld_overflow,
  output logic [NBANKS-1:0] bank_valid
);
  localparam int NL    = DW / 8;
  localparam int LW    = (NL > 1) ? $clog2(NL) : 1;
  localparam int DEPTH = 1 << (BW + AW);

  typedef enum logic [1:0] {IDLE, LOAD, FULL} state_t;

  state_t          state, state_nx;
  logic [BW-1:0]   cur_bank;
  logic [AW-1:0]   ptr;
  logic [LW-1:0]   lane;
  logic [DW-1:0]   hold;
  logic [DW-1:0]   word_nx;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   rdata;
  logic [DW-1:0]   mem [DEPTH];
  logic            start_ok, xfer, last_lane, last_word;
  logic            we, set_valid, set_ovf, rd_ok;

  assign start_ok  = ld_start && (32'(ld_bank) < 32'(NBANKS));
  assign last_lane = (lane == LW'(NL - 1));
  assign last_word = (ptr == '1);
  assign rd_ok     = (32'(bank) < 32'(NBANKS)) && bank_valid[bank];
  assign wdata     = xfer ? word_nx : hold;
  assign d         = oe ? rdata : '0;

  always_comb begin
    state_nx  = state;
    we        = 1'b0;
    set_valid = 1'b0;
    set_ovf   = 1'b0;
    xfer      = 1'b0;
    ld_ready  = (state == LOAD);
    ld_busy   = (state == LOAD);
    word_nx   = hold;
    for (int i = 0; i < NL; i++) begin
      if (lane == LW'(i)) word_nx[i*8 +: 8] = ld_data;
    end
    case (state)
      IDLE: if (start_ok) state_nx = LOAD;
      LOAD: begin
        if (!start_ok) begin
          xfer = ld_valid;
          if (xfer && last_lane) begin
            we = 1'b1;
            if (last_word) begin
              set_valid = 1'b1;
              state_nx  = FULL;
            end
          end
          // a bank that just filled completely wins over an early finish
          if (ld_finish && !(xfer && last_lane && last_word)) begin
            set_valid = 1'b1;
            state_nx  = IDLE;
            if (xfer || lane != '0) we = 1'b1;
          end
        end
      end
      FULL: begin
        if (start_ok) state_nx = LOAD;
        else if (ld_valid) set_ovf = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cur_bank    <= '0;
      ptr         <= '0;
      lane        <= '0;
      hold        <= '0;
      bank_valid  <= '0;
      ld_overflow <= 1'b0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        cur_bank            <= ld_bank;
        ptr                 <= '0;
        lane                <= '0;
        hold                <= '0;
        bank_valid[ld_bank] <= 1'b0;
        ld_overflow         <= 1'b0;
      end else begin
        if (set_ovf) ld_overflow <= 1'b1;
        if (set_valid) bank_valid[cur_bank] <= 1'b1;
        if (xfer) begin
          if (last_lane) begin
            lane <= '0;
            hold <= '0;
            if (!last_word) ptr <= ptr + 1'b1;
          end else begin
            lane <= lane + 1'b1;
            hold <= word_nx;
          end
        end
        if (state == LOAD && state_nx == IDLE) begin
          lane <= '0;
          hold <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[{cur_bank, ptr}] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rdata <= '0;
    else if (ce) rdata <= rd_ok ? mem[{bank, a}] : '0;
  end
endmodule

// File: tb/tb_rom_loader_bank.sv
// tb/tb_rom_loader_bank.sv - randomized self-checking bench for rom_loader_bank against a byte-queue model
module tb_rom_loader_bank;
  localparam int AW = 4, DW = 16, NB = 3, BW = 2;
  localparam int WORDS = 1 << AW;
  localparam int NBYTES = WORDS * (DW / 8);

  logic          clk = 0, reset_n = 0;
  logic [AW-1:0] a = '0;
  logic [BW-1:0] bank = '0;
  logic          ce = 0, oe = 0;
  logic [DW-1:0] d;
  logic          ld_start = 0, ld_valid = 0, ld_finish = 0;
  logic [BW-1:0] ld_bank = '0;
  logic [7:0]    ld_data = '0;
  logic          ld_ready, ld_busy, ld_overflow;
  logic [NB-1:0] bank_valid;

  rom_loader_bank #(.AW(AW), .DW(DW), .NBANKS(NB)) dut (
    .clk(clk), .reset_n(reset_n), .a(a), .bank(bank), .ce(ce), .oe(oe), .d(d),
    .ld_start(ld_start), .ld_bank(ld_bank), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready), .ld_finish(ld_finish), .ld_busy(ld_busy),
    .ld_overflow(ld_overflow), .bank_valid(bank_valid)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit chk = 0;

  // model: per-bank word arrays, byte queue for the word being assembled
  logic [DW-1:0] mmem [0:NB-1][0:WORDS-1];
  bit            mwr  [0:NB-1][0:WORDS-1];
  logic [NB-1:0] mvalid = '0;
  bit            mloading = 0, mfull = 0, movf = 0, mrd_known = 1;
  int            mbank = 0, mcnt = 0;
  logic [DW-1:0] mrd = '0;
  logic [7:0]    pend [$];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_flush();
    logic [7:0] hi;
    hi = (pend.size() > 1) ? pend[1] : 8'h00;
    mmem[mbank][(mcnt - 1) / 2] = {hi, pend[0]};
    mwr[mbank][(mcnt - 1) / 2] = 1;
    pend.delete();
  endtask

  always @(posedge clk) begin
    if (!reset_n) begin
      mloading = 0; mfull = 0; movf = 0; mvalid = '0; mrd = '0; mrd_known = 1;
      pend.delete();
    end else begin
      if (ce) begin
        if (int'(bank) < NB && mvalid[bank]) begin
          mrd = mmem[bank][a];
          mrd_known = mwr[bank][a];
        end else begin
          mrd = '0;
          mrd_known = 1;
        end
      end
      if (ld_start && int'(ld_bank) < NB) begin
        mloading = 1; mfull = 0; movf = 0; mbank = ld_bank; mcnt = 0;
        pend.delete();
        mvalid[ld_bank] = 0;
      end else if (mloading) begin
        if (ld_valid) begin
          pend.push_back(ld_data);
          mcnt++;
          if (pend.size() == 2) model_flush();
        end
        if (mcnt == NBYTES) begin
          mvalid[mbank] = 1; mloading = 0; mfull = 1;
        end else if (ld_finish) begin
          if (pend.size() != 0) model_flush();
          mvalid[mbank] = 1; mloading = 0;
        end
      end else if (mfull && ld_valid) begin
        movf = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      cmp("ld_ready", ld_ready, mloading);
      cmp("ld_busy", ld_busy, mloading);
      cmp("ld_overflow", ld_overflow, movf);
      cmp("bank_valid", bank_valid, mvalid);
      if (mrd_known) cmp("d", d, oe ? mrd : '0);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b, input logic fin);
    ld_valid = 1; ld_data = b; ld_finish = fin;
    cyc();
    ld_valid = 0; ld_finish = 0;
  endtask

  task automatic start(input int b);
    ld_start = 1; ld_bank = BW'(b);
    cyc();
    ld_start = 0;
  endtask

  task automatic rd(input int b, input int adr);
    ce = 1; bank = BW'(b); a = AW'(adr);
    cyc();
    ce = 0;
    @(negedge clk);
  endtask

  initial begin
    reset_n = 0; ce = 1; oe = 1;
    @(posedge clk);
    chk = 1;
    #2;
    cyc();
    @(negedge clk);
    cmp("rst_d", d, 16'h0);
    cmp("rst_valid", bank_valid, 3'b000);
    cmp("rst_ready", ld_ready, 1'b0);
    cmp("rst_ovf", ld_overflow, 1'b0);
    reset_n = 1; ce = 0;
    cyc();

    start(3);
    @(negedge clk);
    cmp("bad_bank_busy", ld_busy, 1'b0);

    start(1);
    for (int i = 0; i < NBYTES; i++) send(8'(8'h10 + i), 1'b0);
    @(negedge clk);
    cmp("full_ready", ld_ready, 1'b0);
    cmp("full_valid", bank_valid, 3'b010);
    rd(1, 5);
    cmp("read_w5", d, 16'h1B1A);
    oe = 0; #1;
    cmp("oe_gate", d, 16'h0);
    a = 0; bank = 0; cyc();
    oe = 1; #1;
    cmp("ce_hold", d, 16'h1B1A);

    ld_valid = 1; ld_data = 8'hEE; cyc(); ld_valid = 0;
    @(negedge clk);
    cmp("ovf_set", ld_overflow, 1'b1);
    rd(1, 15);
    cmp("no_ovf_write", d, 16'h2F2E);
    start(1);
    @(negedge clk);
    cmp("ovf_clr", ld_overflow, 1'b0);
    cmp("restart_valid", bank_valid, 3'b000);
    rd(1, 5);
    cmp("read_loading", d, 16'h0);

    start(0);
    send(8'h34, 0); send(8'h12, 0); send(8'h78, 0); send(8'h56, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 1);
    @(negedge clk);
    cmp("finish_valid", bank_valid, 3'b001);
    cmp("model_w3", mmem[0][3], 16'h00CC);
    rd(0, 0); cmp("asm_w0", d, 16'h1234);
    rd(0, 1); cmp("asm_w1", d, 16'h5678);
    rd(0, 3); cmp("asm_pad", d, 16'h00CC);
    rd(3, 0); cmp("bank_oor", d, 16'h0);

    start(2);
    for (int i = 0; i < 7; i++) send(8'($urandom), 1'b0);
    reset_n = 0; cyc(); reset_n = 1;
    @(negedge clk);
    cmp("midrst_busy", ld_busy, 1'b0);
    cmp("midrst_valid", bank_valid, 3'b000);
    start(2);
    for (int i = 0; i < NBYTES; i++) send(8'(i * 3 + 1), 1'b0);
    @(negedge clk);
    cmp("reload_valid", bank_valid, 3'b100);
    rd(2, 0); cmp("reload_w0", d, 16'h0401);

    for (int n = 0; n < 4000; n++) begin
      reset_n   = ($urandom % 600) != 0;
      ld_start  = ($urandom % 45) == 0;
      ld_bank   = BW'($urandom % 4);
      ld_valid  = ($urandom % 5) != 0;
      ld_data   = 8'($urandom);
      ld_finish = ($urandom % 60) == 0;
      ce        = $urandom % 2;
      oe        = ($urandom % 4) != 0;
      a         = AW'($urandom);
      bank      = BW'($urandom % 4);
      cyc();
    end
    ld_start = 0; ld_valid = 0; ld_finish = 0;
    cyc();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rom_loader_bank.md
# rom_loader_bank

Parametrised, host-loadable program ROM for the arcade core: NBANKS independent banks of 2^AW words × DW bits. Banks are filled at run time from a byte-wide load stream with valid/ready handshake, little-endian word assembly and auto-increment. The CPU reads them through a registered, single-cycle-latency port gated by ce/oe. It replaces fixed, image-initialised ROMs, so one bitstream can run different ROM sets. Per-bank valid flags block reads of banks that are unloaded or currently loading.

## Interface
- AW, 13, word address width per bank
- DW, 8, data width; multiple of 8, range 8..32
- NBANKS, 2, number of banks, at least 1
- BW, derived = max(1, clog2(NBANKS)), bank select width
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset; one clock, sampled on rising edge
- a  in  AW  CPU word address
- bank  in  BW  CPU bank select
- ce  in  1  CPU chip enable
- oe  in  1  CPU output enable
- d  out  DW  CPU read data, registered
- ld_start  in  1  one-cycle pulse: begin load of ld_bank at word 0
- ld_bank  in  BW  target bank, sampled with ld_start
- ld_valid  in  1  load byte valid
- ld_data  in  8  load byte
- ld_ready  out  1  block accepts byte this cycle
- ld_finish  in  1  one-cycle pulse: end load early, mark bank valid
- ld_busy  out  1  load in progress
- ld_overflow  out  1  sticky: a byte was offered after the bank was full
- bank_valid  out  NBANKS  per-bank loaded flag

## Operation
- The FSM has three states: IDLE, LOAD and FULL.
- **IDLE**
  - ld_ready=0, ld_busy=0.
  - ld_start: latch ld_bank, clear the word pointer and byte lane, clear bank_valid[ld_bank], go to LOAD.
  - An out-of-range ld_bank (≥NBANKS) is ignored; the FSM stays in IDLE.
- **LOAD**
  - ld_ready=1, ld_busy=1.
  - A byte transfers when ld_valid & ld_ready.
  - Bytes fill lanes 0..DW/8-1, LSB lane first, into a word holding register.
  - When the last lane fills, the assembled word is written to mem[bank][ptr] in the same cycle and ptr increments.
- **LOAD exit conditions**
  - Last lane of word 2^AW-1 written: set bank_valid, go to FULL. The pointer does not wrap.
  - ld_finish: zero-pad a partial word and write it, set bank_valid, go to IDLE. If a transfer occurs in the same cycle, that byte is included before padding.
  - ld_start in LOAD: abandon the current load, do not set valid, restart on the new ld_bank. Earlier words are left as written.
- **FULL**
  - ld_ready=0, ld_busy=0.
  - ld_valid=1 sets ld_overflow; the byte is dropped.
  - ld_start behaves as in IDLE; that transition clears ld_overflow. ld_finish is ignored.
- **Read port**
  - On each clock with ce=1, the registered data is updated: mem[bank][a] if bank_valid[bank] and bank<NBANKS, else 0.
  - With ce=0 the registered data holds.
  - d = registered data when oe=1, else 0. This gating is combinational.
- Reads and loads are independent. Reading the bank under load returns 0 because its valid flag is clear.
- **Reset** (any state, including mid-load)
  - FSM to IDLE; pointer, lane and holding register to 0.
  - bank_valid=0, ld_overflow=0, read data register=0.
  - Memory contents are not cleared.

## Timing
- Reset values: d=0, ld_ready=0, ld_busy=0, ld_overflow=0, bank_valid=0.
- Read latency is 1 clock: a/bank/ce presented at edge N give data on d after edge N+1's update, held until the next ce edge.
- ld_start at edge N: ld_ready=1 and ld_busy=1 from N+1; the first byte can be accepted at edge N+1.
- Sustained throughput is 1 byte per clock; ld_ready is never deasserted within LOAD.
- Final-word write at edge M: bank_valid=1 from M+1, and a read issued at M+1 returns the new data at M+2.
- ld_finish at edge M: padded write and valid both take effect from M+1.
- Same-address read and write in one cycle (only possible after a restart over an already-valid bank, which is excluded because valid is cleared) needs no defined ordering.
- Memory is inferred as synchronous block RAM: one write port, one read port.

## Test plan
- **Reset:** hold reset_n=0 for 2 clocks with ce=oe=1 → d=0, bank_valid=0, ld_ready=0, ld_overflow=0.
- **Full load (DW=8, AW=4):** ld_start bank 1, stream bytes 0x10..0x1F back-to-back → ld_ready falls after the 16th byte, bank_valid=2'b10. Then read a=5 bank=1 → d=0x15 one clock later; oe=0 → d=0.
- **Word assembly (DW=16):** load bytes 0x34,0x12,0x78,0x56 → mem[0]=0x1234, mem[1]=0x5678. Then 3 more bytes, then ld_finish → mem[3] lower byte = last byte, upper byte 0x00, bank valid.
- **Overflow and restart:** after FULL, offer ld_valid=1 → ld_overflow=1, no write. ld_start same bank → ld_overflow=0, bank_valid bit clear, reads return 0 until reload completes.
- **Reset mid-load:** 7 bytes into a load, pulse reset_n=0 → FSM idle, bank_valid=0, ld_busy=0. A subsequent full load succeeds from word 0.
- **ce hold and invalid bank:** read valid data, drop ce, change a → d unchanged. Read bank index ≥ NBANKS (NBANKS=3) → d=0.
